// File: rtl/npc_pred_pkg.sv
// npc_pred_pkg
//   Shared derivations and helpers for the next-PC predictor.
//   - index_w / tag_w : BTB index and tag widths from PC width and entry count
//   - ctr_max / ctr_wnt / ctr_wt : direction counter constants for a given width
//   - ctr_step : saturating increment/decrement used for every counter update
package npc_pred_pkg;

    function automatic int index_w(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int tag_w(input int pc_w, input int entries);
        return pc_w - $clog2(entries) - 2;
    endfunction

    function automatic int ctr_max(input int ctr_w);
        return (1 << ctr_w) - 1;
    endfunction

    // weakly-not-taken: just below the MSB threshold
    function automatic int ctr_wnt(input int ctr_w);
        return (1 << (ctr_w - 1)) - 1;
    endfunction

    // weakly-taken: lowest value with the MSB set
    function automatic int ctr_wt(input int ctr_w);
        return 1 << (ctr_w - 1);
    endfunction

    // Counter is carried in a 32-bit container so one function serves any CTR_W.
    function automatic logic [31:0] ctr_step(input logic [31:0] ctr, input logic inc,
                                             input int ctr_w);
        logic [31:0] lim;
        lim = 32'(ctr_max(ctr_w));
        if (inc)
            return (ctr >= lim) ? lim : ctr + 32'd1;
        else
            return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/npc_ras.sv
// npc_ras
//   Circular return-address stack. Pop is applied before push in the same
//   cycle, so both together replace the top. Pushing while full overwrites the
//   oldest entry; popping while empty does nothing.
// Ports
//   clk, reset    clock / synchronous active-high reset
//   i_push        push i_push_data this cycle
//   i_pop         pop the top entry this cycle
//   i_push_data   return address to push
//   o_top         current top of stack (meaningful only when !o_empty)
//   o_empty       stack holds no entries
module npc_ras #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_push_data,
    output logic [W-1:0] o_top,
    output logic         o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_do_pop;
    logic [PTR_W-1:0] w_ptr_pop;
    logic [PTR_W-1:0] w_ptr_push;
    logic [CNT_W-1:0] w_cnt_pop;

    always_comb begin
        w_do_pop   = i_pop && (r_cnt != '0);
        w_ptr_pop  = r_ptr;
        w_cnt_pop  = r_cnt;
        if (w_do_pop) begin
            w_ptr_pop = (r_ptr == '0) ? PTR_LAST : r_ptr - PTR_W'(1);
            w_cnt_pop = r_cnt - CNT_W'(1);
        end
        w_ptr_push = (w_ptr_pop == PTR_LAST) ? '0 : w_ptr_pop + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (i_push) begin
            r_ptr <= w_ptr_push;
            r_cnt <= (w_cnt_pop == CNT_FULL) ? CNT_FULL : w_cnt_pop + CNT_W'(1);
        end else begin
            r_ptr <= w_ptr_pop;
            r_cnt <= w_cnt_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && i_push)
            r_mem[w_ptr_push] <= i_push_data;
    end

    assign o_top   = r_mem[r_ptr];
    assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/npc_predictor.sv
// npc_predictor
//   Next-PC predictor: direct-mapped BTB with saturating direction counters.
//   Lookup is combinational off the registered table (no bypass of a
//   same-cycle update); training happens at posedge from the ID stage.
//   Optional feature macro: NPC_RAS_EN adds a return-address stack that
//   overrides the target of entries trained as returns.
// Ports
//   clk, reset     clock / synchronous active-high reset
//   lu_pc          IF-stage PC being fetched
//   lu_hit         valid entry with matching tag
//   lu_taken       hit and counter MSB set
//   lu_target      predicted next PC (lu_pc+4 when not taken)
//   upd_valid      a control-transfer instruction resolved this cycle
//   upd_pc         its PC
//   upd_taken      actual outcome
//   upd_target     actual target when taken
//   upd_is_call    taken call (RAS push of upd_pc+8)
//   upd_is_ret     jr $ra (RAS pop)
module npc_predictor
    import npc_pred_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int ENTRIES   = 16,
    parameter int CTR_W     = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] lu_pc,
    output logic            lu_hit,
    output logic            lu_taken,
    output logic [PC_W-1:0] lu_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_is_call,
    input  logic            upd_is_ret
);

    localparam int IDX_W = index_w(ENTRIES);
    localparam int TAG_W = tag_w(PC_W, ENTRIES);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_wnt(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_wt(CTR_W));

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [CTR_W-1:0] ctr;
        logic             is_ret;
    } entry_t;

    entry_t r_tab [ENTRIES];

    logic [IDX_W-1:0] w_lu_idx, w_upd_idx;
    logic [TAG_W-1:0] w_lu_tag, w_upd_tag;
    entry_t           w_lu_e;
    logic             w_upd_hit;
    logic [CTR_W-1:0] w_ctr_inc, w_ctr_dec;
    logic [PC_W-1:0]  w_pred_tgt;
    logic             w_new_is_ret;

    assign w_lu_idx  = lu_pc[IDX_W+1:2];
    assign w_lu_tag  = lu_pc[PC_W-1:IDX_W+2];
    assign w_upd_idx = upd_pc[IDX_W+1:2];
    assign w_upd_tag = upd_pc[PC_W-1:IDX_W+2];

    assign w_lu_e    = r_tab[w_lu_idx];
    assign lu_hit    = w_lu_e.valid && (w_lu_e.tag == w_lu_tag);
    assign lu_taken  = lu_hit && w_lu_e.ctr[CTR_W-1];
    assign lu_target = lu_taken ? w_pred_tgt : lu_pc + PC_W'(4);

    assign w_upd_hit = r_tab[w_upd_idx].valid && (r_tab[w_upd_idx].tag == w_upd_tag);
    assign w_ctr_inc = CTR_W'(ctr_step(32'(r_tab[w_upd_idx].ctr), 1'b1, CTR_W));
    assign w_ctr_dec = CTR_W'(ctr_step(32'(r_tab[w_upd_idx].ctr), 1'b0, CTR_W));

`ifdef NPC_RAS_EN
    logic            w_ras_empty;
    logic [PC_W-1:0] w_ras_top;

    // call returns past its delay slot
    npc_ras #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
        .clk         (clk),
        .reset       (reset),
        .i_push      (upd_valid && upd_is_call),
        .i_pop       (upd_valid && upd_is_ret),
        .i_push_data (upd_pc + PC_W'(8)),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty)
    );

    assign w_pred_tgt   = (w_lu_e.is_ret && !w_ras_empty) ? w_ras_top : w_lu_e.target;
    assign w_new_is_ret = upd_is_ret;
`else
    logic w_unused_cfg;

    assign w_pred_tgt   = w_lu_e.target;
    assign w_new_is_ret = 1'b0;
    assign w_unused_cfg = ^{upd_is_call, upd_is_ret, upd_pc[1:0], w_lu_e.is_ret,
                            32'(RAS_DEPTH)};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_tab[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT, is_ret: 1'b0};
            end
        end else if (upd_valid) begin
            if (w_upd_hit) begin
                if (upd_taken) begin
                    r_tab[w_upd_idx].ctr    <= w_ctr_inc;
                    r_tab[w_upd_idx].target <= upd_target;
                    r_tab[w_upd_idx].is_ret <= w_new_is_ret;
                end else begin
                    r_tab[w_upd_idx].ctr <= w_ctr_dec;
                end
            end else if (upd_taken) begin
                r_tab[w_upd_idx] <= '{valid: 1'b1, tag: w_upd_tag, target: upd_target,
                                      ctr: CTR_WT, is_ret: w_new_is_ret};
            end
        end
    end

endmodule
